uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter SYS_CLK_FREQ, default 1000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, serial bit rate in bit/s.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, data bits per frame.
REQ-004 SHALL have port sys_clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port areset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port data_in  input  1  serial line, idle high, asynchronous to sys_clk.
REQ-007 SHALL have port data  output  DATA_WIDTH  last received word.
REQ-008 SHALL have port data_valid  output  1  one-cycle pulse, data holds a new word.
REQ-009 SHALL have port framing_error  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 SHALL have port parity_error  output  1  one-cycle pulse, parity mismatch (see Configuration).
REQ-011 SHALL have port busy  output  1  high while a frame is in progress.

Function
REQ-012 SHALL pass data_in through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-013 SHALL use BIT_CNT = SYS_CLK_FREQ/BAUD_RATE (integer division) sys_clk cycles per bit; HALF = BIT_CNT/2.
REQ-014 SHALL implement states IDLE, START, DATA, STOP (plus PARITY when enabled) and WAIT_HIGH.
REQ-015 IDLE: synchronized line low -> START, counter cleared, busy asserted the next cycle.
REQ-016 START: sample at HALF cycles; line high -> false start, return to IDLE, no pulses; line low -> DATA.
REQ-017 DATA: sample every BIT_CNT cycles after the start mid-point, LSB first, DATA_WIDTH samples, then STOP.
REQ-018 STOP: sample one BIT_CNT later; high -> load data, pulse data_valid, go to IDLE; low -> pulse framing_error, data unchanged, go to WAIT_HIGH.
REQ-019 WAIT_HIGH: remain until the synchronized line is high, then IDLE; no start detection while here.
REQ-020 Return to IDLE SHALL occur at the stop-bit mid-point, so a start bit beginning right after a stop bit is accepted.
REQ-021 data_valid, framing_error and parity_error SHALL be mutually exclusive and each exactly one cycle wide.
REQ-022 data SHALL hold its value until the next data_valid.
REQ-023 busy SHALL be low in IDLE and high in every other state.
REQ-024 Counters SHALL be sized $clog2(BIT_CNT)+1 bits and SHALL never wrap within a bit period.

Reset
REQ-025 areset_n low SHALL immediately force IDLE; data=0, data_valid=0, framing_error=0, parity_error=0, busy=0; synchronizer flops=1.
REQ-026 Reset mid-frame SHALL discard the partial frame; after release, reception restarts on the next falling edge.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: one even-parity bit follows the data bits (PARITY state, sampled one BIT_CNT after the last data bit); a mismatch with a good stop bit pulses parity_error instead of data_valid, and data is not updated.
REQ-028 Macro UART_RX_PARITY_EN undefined: no parity bit is expected, the PARITY state is absent, and parity_error is tied 0.

Verification (SYS_CLK_FREQ=1000000, BAUD_RATE=9600, BIT_CNT=104, DATA_WIDTH=8)
REQ-029 Frame 0xA5 with stop=1 -> data=0xA5, single data_valid pulse at the stop mid-point, busy low the next cycle.
REQ-030 Low glitch of 30 cycles on an idle line -> no pulses; busy returns low after the HALF sample.
REQ-031 Frame 0x3C with stop=0, line held low for 2000 cycles -> single framing_error pulse, data unchanged, no reception until the line goes high.
REQ-032 Back-to-back frames 0x00 then 0xFF, the second start bit directly after the first stop bit -> two data_valid pulses with data 0x00 then 0xFF.
REQ-033 areset_n pulsed low during bit 4 of a frame, then frame 0x81 sent -> no pulse for the aborted frame; data=0x81 with data_valid.
REQ-034 With UART_RX_PARITY_EN defined: 0x07 with parity bit 0 -> parity_error pulse and no data_valid; 0x07 with parity bit 1 -> data_valid with data=0x07.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx - asynchronous serial receiver (start bit, DATA_WIDTH data bits LSB
// first, optional even-parity bit, one stop bit). The line is sampled once per
// bit at its mid-point, timed from the falling edge of the start bit.
//
// Optional feature: define UART_RX_PARITY_EN to expect one even-parity bit
// between the last data bit and the stop bit. When the macro is undefined no
// parity bit is expected and parity_error is tied low.
//
// Parameters:
//   SYS_CLK_FREQ  system clock frequency in Hz
//   BAUD_RATE     serial bit rate in bit/s
//   DATA_WIDTH    data bits per frame (2 or more)
// Ports:
//   sys_clk        system clock, rising edge
//   areset_n       asynchronous active-low reset
//   data_in        serial line, idle high, asynchronous to sys_clk
//   data           last correctly received word
//   data_valid     one-cycle pulse, data holds a new word
//   framing_error  one-cycle pulse, stop bit sampled low
//   parity_error   one-cycle pulse, parity mismatch with a good stop bit
//   busy           high while a frame is in progress
module uart_rx #(
  parameter int SYS_CLK_FREQ = 1000000,
  parameter int BAUD_RATE    = 9600,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  sys_clk,
  input  logic                  areset_n,
  input  logic                  data_in,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_valid,
  output logic                  framing_error,
  output logic                  parity_error,
  output logic                  busy
);

  localparam int BIT_CNT = SYS_CLK_FREQ / BAUD_RATE;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CNT_W   = $clog2(BIT_CNT) + 1;
  localparam int IDX_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [DATA_WIDTH-1:0]   shift;
  logic                    rx_p0;
  logic                    rx_p1;
`ifdef UART_RX_PARITY_EN
  logic                    par_bit;
`endif

  // Stage p0/p1: two-flop synchronizer; reset to the idle (high) line level
  always_ff @(posedge sys_clk or negedge areset_n) begin
    if (!areset_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= data_in;
      rx_p1 <= rx_p0;
    end
  end

  // Receive FSM: all decisions on the synchronized line rx_p1
  always_ff @(posedge sys_clk or negedge areset_n) begin
    if (!areset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      shift         <= '0;
      data          <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit       <= 1'b0;
      parity_error  <= 1'b0;
`endif
    end else begin
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (!rx_p1) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_END) begin
            cnt <= '0;
            // A line that is high again at mid start bit was only a glitch
            if (rx_p1) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            shift <= {rx_p1, shift[DATA_WIDTH-1:1]};
            idx   <= idx + IDX_ONE;
            if (idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_END) begin
            cnt     <= '0;
            par_bit <= rx_p1;
            state   <= STOP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
`endif
        STOP: begin
          if (cnt == BIT_END) begin
            cnt <= '0;
            // Leave at the stop mid-point so an immediately following start
            // bit is still caught from its falling edge.
            if (rx_p1) begin
              state <= IDLE;
              busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              if ((^shift) != par_bit) begin
                parity_error <= 1'b1;
              end else begin
                data       <= shift;
                data_valid <= 1'b1;
              end
`else
              data       <= shift;
              data_valid <= 1'b1;
`endif
            end else begin
              framing_error <= 1'b1;
              state         <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        WAIT_HIGH: begin
          // A line stuck low (break) must not be taken as a new start bit
          if (rx_p1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx - directed bench for uart_rx at 1 MHz / 9600 baud (104 clocks
// per bit), 8 data bits. Table of frames plus hand-written sequences for
// timing, glitch, break, back-to-back and mid-frame reset.
module tb_uart_rx;

  localparam int BIT  = 104;
  localparam int HALF = 52;

  logic       sys_clk  = 1'b0;
  logic       areset_n = 1'b0;
  logic       data_in  = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_error;
  logic       parity_error;
  logic       busy;

  always #5 sys_clk = ~sys_clk;

  uart_rx #(
    .SYS_CLK_FREQ(1000000),
    .BAUD_RATE   (9600),
    .DATA_WIDTH  (8)
  ) dut (
    .sys_clk      (sys_clk),
    .areset_n     (areset_n),
    .data_in      (data_in),
    .data         (data),
    .data_valid   (data_valid),
    .framing_error(framing_error),
    .parity_error (parity_error),
    .busy         (busy)
  );

  int checks = 0;
  int errors = 0;

  // Pulse monitor, sampled on the falling edge
  int   cyc = 0;
  int   dv_cnt = 0, fe_cnt = 0, pe_cnt = 0;
  int   dv_cyc = 0;
  int   excl_bad = 0, wide_bad = 0;
  logic prev_dv = 1'b0, prev_fe = 1'b0, prev_pe = 1'b0;
  logic busy_after_dv = 1'b1;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (data_valid) begin
      dv_cnt <= dv_cnt + 1;
      dv_cyc <= cyc;
    end
    if (framing_error) fe_cnt <= fe_cnt + 1;
    if (parity_error)  pe_cnt <= pe_cnt + 1;
    if ((int'(data_valid) + int'(framing_error) + int'(parity_error)) > 1)
      excl_bad <= excl_bad + 1;
    if ((data_valid && prev_dv) || (framing_error && prev_fe) || (parity_error && prev_pe))
      wide_bad <= wide_bad + 1;
    if (prev_dv) busy_after_dv <= busy;
    prev_dv <= data_valid;
    prev_fe <= framing_error;
    prev_pe <= parity_error;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    data_in = b;
    wait_clk(BIT);
  endtask

  // Start, data LSB first, [even parity ^ flip], stop. Returns 1 time unit
  // after the clock edge that ends the stop bit; the line keeps the stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip);
    logic [10:0] fr;
    int          nb;
`ifdef UART_RX_PARITY_EN
    fr = {stop, (^d) ^ flip, d, 1'b0};
    nb = 11;
`else
    fr = {flip, stop, d, 1'b0};
    nb = 10;
`endif
    for (int i = 0; i < nb; i++) drive_bit(fr[i]);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       flip;
    logic       exp_dv;
    logic       exp_fe;
    logic       exp_pe;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int b_dv, b_fe, b_pe, c0, lat;

    vecs.push_back('{8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A});
    vecs.push_back('{8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A});
    vecs.push_back('{8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01});
    vecs.push_back('{8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h80});
    vecs.push_back('{8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h07});
`endif

    // Reset state
    wait_clk(3);
    check("rst_data", data, 8'h00);
    check("rst_dv", data_valid, 0);
    check("rst_fe", framing_error, 0);
    check("rst_pe", parity_error, 0);
    check("rst_busy", busy, 0);
    areset_n = 1'b1;
    wait_clk(5);

    // 0xA5: valid pulse at the stop mid-point, busy low the cycle after
    b_dv = dv_cnt;
    c0 = cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    wait_clk(5);
    check("a5_dv", dv_cnt - b_dv, 1);
    check("a5_data", data, 8'hA5);
    lat = dv_cyc - c0;
    check("a5_stop_mid", int'(lat >= 9*BIT + HALF - 4 && lat <= 9*BIT + HALF + 4), 1);
    check("a5_busy_next", busy_after_dv, 0);

    // 30-cycle low glitch on an idle line
    b_dv = dv_cnt; b_fe = fe_cnt; b_pe = pe_cnt;
    data_in = 1'b0;
    wait_clk(20);
    check("glitch_busy_hi", busy, 1);
    wait_clk(10);
    data_in = 1'b1;
    wait_clk(70);
    check("glitch_busy_lo", busy, 0);
    check("glitch_pulses", (dv_cnt - b_dv) + (fe_cnt - b_fe) + (pe_cnt - b_pe), 0);

    // 0x3C with low stop bit, then the line held low for 2000 cycles
    b_dv = dv_cnt; b_fe = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_clk(2000);
    check("brk_fe", fe_cnt - b_fe, 1);
    check("brk_dv", dv_cnt - b_dv, 0);
    check("brk_data", data, 8'hA5);
    check("brk_busy_hi", busy, 1);
    data_in = 1'b1;
    wait_clk(10);
    check("brk_busy_lo", busy, 0);

    // Table of frames
    foreach (vecs[i]) begin
      b_dv = dv_cnt; b_fe = fe_cnt; b_pe = pe_cnt;
      send_frame(vecs[i].d, vecs[i].stop, vecs[i].flip);
      data_in = 1'b1;
      wait_clk(5);
      check($sformatf("vec%0d_dv", i), dv_cnt - b_dv, vecs[i].exp_dv);
      check($sformatf("vec%0d_fe", i), fe_cnt - b_fe, vecs[i].exp_fe);
      check($sformatf("vec%0d_pe", i), pe_cnt - b_pe, vecs[i].exp_pe);
      check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
      check($sformatf("vec%0d_busy", i), busy, 0);
    end

    // Back-to-back 0x00 then 0xFF, no idle time between frames
    b_dv = dv_cnt; b_fe = fe_cnt;
    send_frame(8'h00, 1'b1, 1'b0);
    check("b2b_first_dv", dv_cnt - b_dv, 1);
    check("b2b_first_data", data, 8'h00);
    send_frame(8'hFF, 1'b1, 1'b0);
    wait_clk(5);
    check("b2b_second_dv", dv_cnt - b_dv, 2);
    check("b2b_second_data", data, 8'hFF);
    check("b2b_fe", fe_cnt - b_fe, 0);

    // Reset during bit 4 of a frame, then a clean 0x81
    b_dv = dv_cnt; b_fe = fe_cnt; b_pe = pe_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    data_in = 1'b0;
    wait_clk(50);
    areset_n = 1'b0;
    #1;
    check("midrst_data", data, 8'h00);
    check("midrst_busy", busy, 0);
    data_in = 1'b1;
    wait_clk(3);
    areset_n = 1'b1;
    wait_clk(300);
    check("midrst_no_pulse", (dv_cnt - b_dv) + (fe_cnt - b_fe) + (pe_cnt - b_pe), 0);
    send_frame(8'h81, 1'b1, 1'b0);
    wait_clk(5);
    check("after_rst_dv", dv_cnt - b_dv, 1);
    check("after_rst_data", data, 8'h81);

    // Pulse shape over the whole run
    check("pulse_exclusive", excl_bad, 0);
    check("pulse_one_cycle", wide_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
